storage_unit_be_clr: RTL and testbench
======================================

// Module: storage_unit_be_clr
// PURPOSE
//  Parametrised successor to the FF-based storage unit: flip-flop array with independent
//  write and read ports, per-byte write enables, 1- or 2-cycle read latency and a
//  selectable read-during-write policy. A built-in clear engine zeroes the array one word per cycle.
//  Used as the RTL behavioural stand-in for 1W1R SRAM macros in datapath buffers.
// PARAMETERS
//  WIDTH     32  bits per word; must be a multiple of BYTE_W
//  DEPTH     16  number of words; need not be a power of 2
//  BYTE_W     8  bits per write-enable lane; NB = WIDTH/BYTE_W, AW = $clog2(DEPTH)
//  RD_LAT     1  read latency in cycles; legal values 1 or 2
//  RDW_MODE   0  same-address read+write: 0 = return old data, 1 = return new (merged) data
//  CLR_ON_RST 1  1 = run the clear engine automatically after reset; 0 = array not cleared by reset
// PORTS
//  clk      in   1      clock, all logic on posedge
//  rst      in   1      synchronous, active-high reset
//  wr_en    in   1      write request
//  wr_addr  in   AW     write address
//  wr_data  in   WIDTH  write data
//  wr_be    in   NB     byte-lane enables; bit b gates wr_data[b*BYTE_W +: BYTE_W]
//  rd_en    in   1      read request
//  rd_addr  in   AW     read address
//  rd_data  out  WIDTH  read data
//  rd_valid out  1      1-cycle pulse; rd_data is valid while high
//  clr_req  in   1      start a full-array clear (single-cycle pulse)
//  busy     out  1      clear engine active; all port accesses are ignored while high
// BEHAVIOUR
//  Reset (rst=1 at posedge):
//   - rd_data=0, rd_valid=0, read pipeline flushed (in-flight reads discarded)
//   - clr_ptr=0, state=CLEAR if CLR_ON_RST else IDLE
//   - busy reflects state directly, so busy=CLR_ON_RST during and after reset
//   - array flops have no reset; contents persist when CLR_ON_RST=0
//  FSM IDLE:
//   - clr_req=1 -> CLEAR, clr_ptr=0
//   - any wr_en/rd_en in that same cycle is dropped
//  FSM CLEAR:
//   - each cycle: mem[clr_ptr]<=0, clr_ptr++
//   - after writing DEPTH-1 -> IDLE; busy=1 for exactly DEPTH cycles
//   - clr_req ignored while in CLEAR
//   - rst mid-clear aborts; if CLR_ON_RST, clear restarts at 0
//  Write (IDLE, wr_en=1, no clr_req):
//   - lanes with wr_be[b]=1 update at the posedge; other lanes keep their contents
//   - wr_be=0 is a no-op
//   - wr_addr>=DEPTH is ignored
//  Read (IDLE, rd_en=1, no clr_req):
//   - RD_LAT=1: rd_data/rd_valid update at the next posedge
//   - RD_LAT=2: one extra output register stage
//   - back-to-back reads allowed every cycle; full throughput
//   - rd_addr>=DEPTH returns 0 with rd_valid=1
//   - rd_data holds its last value when rd_valid=0
//  Same-cycle write and read to the same address:
//   - RDW_MODE=0: pre-write word
//   - RDW_MODE=1: per lane, wr_data where wr_be set, else stored data
//  A read issued the cycle before clr_req completes normally; reads issued during busy never produce rd_valid.
// TESTING (WIDTH=32, DEPTH=16, BYTE_W=8)
//  - Reset, CLR_ON_RST=1 -> busy=1 for 16 cycles after rst falls. Then read all addresses -> 0x00000000, rd_valid pulses.
//  - Write 0xAABBCCDD be=4'hF @3, then 0x11223344 be=4'b0101 @3 -> read @3 = 0xAA22CC44.
//  - Read @5 at cycle t -> rd_valid at t+1 (RD_LAT=1) or t+2 (RD_LAT=2). Reads @0..15 on consecutive cycles -> 16 consecutive rd_valid.
//  - mem[7]=0x12345678; write 0xCAFEF00D be=4'hF and read @7 same cycle -> 0x12345678 (RDW_MODE=0) or 0xCAFEF00D (RDW_MODE=1).
//  - clr_req with wr_en @2 the same cycle -> write dropped, busy 16 cycles, wr_en/rd_en during busy ignored; read @2 afterwards = 0.
//  - rst asserted at clear cycle 6 -> rd_valid=0; clear restarts and busy lasts 16 cycles. DEPTH=12: write/read @13 -> no write, read returns 0.

Source files
------------

// File: rtl/storage_unit_be_clr.sv
// Flip-flop 1W1R storage array with per-byte write enables and a built-in clear engine.
// Latency: reads return RD_LAT (1 or 2) cycles after rd_en; writes land at the next posedge.
// Backpressure: none on the ports; while busy (clearing) every read and write is dropped.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   wr_en/wr_addr/wr_data/wr_be   write port, byte lanes gated by wr_be
//   rd_en/rd_addr       read request
//   rd_data/rd_valid    read result, rd_valid is a 1-cycle pulse, rd_data holds otherwise
//   clr_req             pulse to zero the whole array, one word per cycle
//   busy                clear engine running
module storage_unit_be_clr #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 16,
  parameter int BYTE_W     = 8,
  parameter int RD_LAT     = 1,
  parameter int RDW_MODE   = 0,
  parameter int CLR_ON_RST = 1,
  localparam int NB        = WIDTH / BYTE_W,
  localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [NB-1:0]    wr_be,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  input  logic             clr_req,
  output logic             busy
);

  typedef enum logic {IDLE, CLEAR} state_t;

  // One extra bit so DEPTH itself is representable for range checks.
  localparam logic [AW:0]   DEPTH_C   = DEPTH[AW:0];
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];

  state_t          state;
  logic [AW-1:0]   clr_ptr;

  logic            accept;
  logic            wr_fire;
  logic            rd_fire;
  logic            rd_in_range;
  logic [WIDTH-1:0] rd_word;

  assign busy        = (state == CLEAR);
  // A clr_req cycle swallows any access presented alongside it.
  assign accept      = (state == IDLE) && !clr_req;
  assign wr_fire     = accept && wr_en && ({1'b0, wr_addr} < DEPTH_C);
  assign rd_fire     = accept && rd_en;
  assign rd_in_range = ({1'b0, rd_addr} < DEPTH_C);

  // Clear engine FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= (CLR_ON_RST != 0) ? CLEAR : IDLE;
      clr_ptr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (clr_req) begin
            state   <= CLEAR;
            clr_ptr <= '0;
          end
        end
        CLEAR: begin
          if (clr_ptr == LAST_ADDR) begin
            state   <= IDLE;
            clr_ptr <= '0;
          end else begin
            clr_ptr <= clr_ptr + AW'(1);
          end
        end
        default: begin
          state   <= IDLE;
          clr_ptr <= '0;
        end
      endcase
    end
  end

  // Storage array: deliberately unreset so contents survive rst when CLR_ON_RST=0.
  // Writes are suppressed during the rst cycle so an aborted clear cannot race a restart.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) begin
        mem[clr_ptr] <= '0;
      end else if (wr_fire) begin
        for (int b = 0; b < NB; b++) begin
          if (wr_be[b]) begin
            mem[wr_addr][b*BYTE_W +: BYTE_W] <= wr_data[b*BYTE_W +: BYTE_W];
          end
        end
      end
    end
  end

  // Read word selection; out-of-range addresses read as zero. With RDW_MODE=1 a
  // same-address write is forwarded lane by lane so the read sees the merged word.
  always_comb begin
    rd_word = '0;
    if (rd_in_range) begin
      rd_word = mem[rd_addr];
      if (RDW_MODE == 1 && wr_fire && (wr_addr == rd_addr)) begin
        for (int b = 0; b < NB; b++) begin
          if (wr_be[b]) begin
            rd_word[b*BYTE_W +: BYTE_W] = wr_data[b*BYTE_W +: BYTE_W];
          end
        end
      end
    end
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic [WIDTH-1:0] s1_data;
      logic             s1_vld;

      always_ff @(posedge clk) begin
        if (rst) begin
          s1_data  <= '0;
          s1_vld   <= 1'b0;
          rd_data  <= '0;
          rd_valid <= 1'b0;
        end else begin
          s1_vld   <= rd_fire;
          if (rd_fire) s1_data <= rd_word;
          rd_valid <= s1_vld;
          if (s1_vld) rd_data <= s1_data;
        end
      end
    end else begin : g_lat1
      always_ff @(posedge clk) begin
        if (rst) begin
          rd_data  <= '0;
          rd_valid <= 1'b0;
        end else begin
          rd_valid <= rd_fire;
          if (rd_fire) rd_data <= rd_word;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_storage_unit_be_clr.sv
// Directed bench for storage_unit_be_clr: two instances share stimulus.
// u0: defaults (DEPTH=16, RD_LAT=1, RDW_MODE=0); u1: DEPTH=12, RD_LAT=2, RDW_MODE=1.
module tb_storage_unit_be_clr;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, wr_en, rd_en, clr_req;
  logic [3:0]  wr_addr, rd_addr, wr_be;
  logic [31:0] wr_data;
  logic [31:0] rd_data0, rd_data1;
  logic        rd_valid0, rd_valid1, busy0, busy1;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] m0 [16];
  logic [31:0] m1 [16];

  storage_unit_be_clr #(
    .WIDTH(32), .DEPTH(16), .BYTE_W(8), .RD_LAT(1), .RDW_MODE(0), .CLR_ON_RST(1)
  ) u0 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data0),
    .rd_valid(rd_valid0), .clr_req(clr_req), .busy(busy0)
  );

  storage_unit_be_clr #(
    .WIDTH(32), .DEPTH(12), .BYTE_W(8), .RD_LAT(2), .RDW_MODE(1), .CLR_ON_RST(1)
  ) u1 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1),
    .rd_valid(rd_valid1), .clr_req(clr_req), .busy(busy1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] exp1(input logic [3:0] a);
    return (a < 4'd12) ? m1[a] : 32'h0;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_models;
    for (int i = 0; i < 16; i++) begin
      m0[i] = '0;
      m1[i] = '0;
    end
  endtask

  task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
    tick();
    wr_en = 1'b0;
    m0[a] = merge(m0[a], d, be);
    if (a < 4'd12) m1[a] = merge(m1[a], d, be);
  endtask

  // Single read: u0 answers after one edge, u1 after two.
  task automatic read_one(input string tag, input logic [3:0] a,
                          input logic [31:0] e0, input logic [31:0] e1);
    rd_en = 1'b1; rd_addr = a;
    tick();
    rd_en = 1'b0;
    check({tag, "_v0"}, rd_valid0, 1'b1);
    check({tag, "_d0"}, rd_data0, e0);
    check({tag, "_v1_early"}, rd_valid1, 1'b0);
    tick();
    check({tag, "_v1"}, rd_valid1, 1'b1);
    check({tag, "_d1"}, rd_data1, e1);
    check({tag, "_v0_after"}, rd_valid0, 1'b0);
  endtask

  // Back-to-back reads of every address, checked against the models.
  task automatic sweep(input string tag);
    logic [3:0] a;
    for (int k = 0; k < 18; k++) begin
      rd_en   = (k < 16);
      rd_addr = 4'(k);
      tick();
      if (k < 16) begin
        a = 4'(k);
        check($sformatf("%s_v0_%0d", tag, k), rd_valid0, 1'b1);
        check($sformatf("%s_d0_%0d", tag, k), rd_data0, m0[a]);
      end else begin
        check($sformatf("%s_v0_idle_%0d", tag, k), rd_valid0, 1'b0);
        check($sformatf("%s_hold0_%0d", tag, k), rd_data0, m0[15]);
      end
      if (k >= 1 && k <= 16) begin
        a = 4'(k - 1);
        check($sformatf("%s_v1_%0d", tag, k), rd_valid1, 1'b1);
        check($sformatf("%s_d1_%0d", tag, k), rd_data1, exp1(a));
      end else begin
        check($sformatf("%s_v1_idle_%0d", tag, k), rd_valid1, 1'b0);
      end
    end
    rd_en = 1'b0;
  endtask

  // Counts cycles each busy is high, bounded at 40.
  task automatic count_busy(output int c0, output int c1);
    c0 = 0; c1 = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy0) c0++;
      if (busy1) c1++;
      if (!busy0 && !busy1) break;
      tick();
    end
  endtask

  int c0, c1;
  logic saw_valid;

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; clr_req = 1'b0;
    wr_addr = '0; rd_addr = '0; wr_be = '0; wr_data = '0;
    clear_models();

    // Reset state
    tick(); tick();
    check("rst_busy0", busy0, 1'b1);
    check("rst_busy1", busy1, 1'b1);
    check("rst_valid0", rd_valid0, 1'b0);
    check("rst_valid1", rd_valid1, 1'b0);
    check("rst_data0", rd_data0, 32'h0);
    check("rst_data1", rd_data1, 32'h0);
    rst = 1'b0;
    count_busy(c0, c1);
    check("rstclr_len0", c0, 32'd16);
    check("rstclr_len1", c1, 32'd12);
    sweep("zero");

    // Byte-lane merge
    do_write(4'd3, 32'hAABBCCDD, 4'hF);
    do_write(4'd3, 32'h11223344, 4'b0101);
    read_one("be_merge", 4'd3, 32'hAA22CC44, 32'hAA22CC44);
    do_write(4'd3, 32'hFFFFFFFF, 4'h0);
    read_one("be_zero", 4'd3, 32'hAA22CC44, 32'hAA22CC44);

    // Read-during-write
    do_write(4'd7, 32'h12345678, 4'hF);
    wr_en = 1'b1; wr_addr = 4'd7; wr_data = 32'hCAFEF00D; wr_be = 4'hF;
    m0[7] = 32'hCAFEF00D; m1[7] = 32'hCAFEF00D;
    read_one("rdw_full", 4'd7, 32'h12345678, 32'hCAFEF00D);
    wr_en = 1'b1; wr_addr = 4'd7; wr_data = 32'h0000BEEF; wr_be = 4'b0011;
    m0[7] = 32'hCAFEBEEF; m1[7] = 32'hCAFEBEEF;
    read_one("rdw_part", 4'd7, 32'hCAFEF00D, 32'hCAFEBEEF);
    wr_en = 1'b0;
    read_one("rdw_after", 4'd7, 32'hCAFEBEEF, 32'hCAFEBEEF);

    // Address 13: in range for u0, out of range for u1
    do_write(4'd13, 32'hDEADBEEF, 4'hF);
    read_one("oor13", 4'd13, 32'hDEADBEEF, 32'h0);
    do_write(4'd0, 32'h01020304, 4'hF);
    do_write(4'd11, 32'hA5A5A5A5, 4'b1001);
    sweep("data");

    // clr_req with a write and a read in the same cycle
    do_write(4'd2, 32'h55555555, 4'hF);
    clr_req = 1'b1; wr_en = 1'b1; wr_addr = 4'd2; wr_data = 32'h99999999; wr_be = 4'hF;
    rd_en = 1'b1; rd_addr = 4'd2;
    tick();
    clr_req = 1'b0;
    check("clr_drop_v0", rd_valid0, 1'b0);
    saw_valid = 1'b0;
    c0 = 0; c1 = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy0) c0++;
      if (busy1) c1++;
      if (rd_valid0 || rd_valid1) saw_valid = 1'b1;
      if (!busy0 && !busy1) break;
      // Keep hammering both ports only while both instances are still clearing.
      wr_en = (i < 10); wr_addr = 4'd4; wr_data = 32'h77777777;
      rd_en = (i < 10); rd_addr = 4'd4;
      clr_req = (i == 3);
      tick();
    end
    wr_en = 1'b0; rd_en = 1'b0; clr_req = 1'b0;
    check("clr_len0", c0, 32'd16);
    check("clr_len1", c1, 32'd12);
    check("clr_no_valid", saw_valid, 1'b0);
    clear_models();
    read_one("clr_rd2", 4'd2, 32'h0, 32'h0);
    sweep("clr");

    // Read issued the cycle before clr_req completes
    do_write(4'd3, 32'h0BADF00D, 4'hF);
    rd_en = 1'b1; rd_addr = 4'd3;
    tick();
    rd_en = 1'b0; clr_req = 1'b1;
    check("pre_clr_v0", rd_valid0, 1'b1);
    check("pre_clr_d0", rd_data0, 32'h0BADF00D);
    tick();
    clr_req = 1'b0;
    check("pre_clr_v1", rd_valid1, 1'b1);
    check("pre_clr_d1", rd_data1, 32'h0BADF00D);
    check("pre_clr_busy", busy0, 1'b1);

    // Reset in the middle of the clear
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_v0", rd_valid0, 1'b0);
    check("midrst_v1", rd_valid1, 1'b0);
    check("midrst_d0", rd_data0, 32'h0);
    check("midrst_d1", rd_data1, 32'h0);
    count_busy(c0, c1);
    check("midrst_len0", c0, 32'd16);
    check("midrst_len1", c1, 32'd12);
    clear_models();
    sweep("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
